dmem_access_ctrl: RTL
=====================

Name: dmem_access_ctrl

Overview:
Sequencer that drives the read and write controls of the D shift-register-queue memory, one layer at a time, across decoding iterations. Per layer it issues NADDR read addresses, each one row group of P rows. It raises wr_en exactly PIPE_LAT cycles after each read, which aligns write-back with the row-calculation pipeline. It alternates layer 0/1, counts iterations, and stops on max_iter or a latched early-termination request.

Parameters:
ADDRESSWIDTH, 5, width of rd_address
NADDR, 20, reads per layer, ceil(Z/P) = ceil(511/26)
PIPE_LAT, 4, cycles from rd_en to the matching wr_en (Dmem output register plus row-calc latency); legal range 1..15
ITERW, 5, width of max_iter and iter_count

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
start  in  1  single-cycle start request; honoured only in IDLE
max_iter  in  ITERW  iteration limit, sampled on an accepted start; 0 is treated as 1
early_term  in  1  stop request; latched while busy, acted on at the end of the current iteration
rd_en  out  1  Dmem read enable
rd_address  out  ADDRESSWIDTH  Dmem read address, 0..NADDR-1
rd_layer  out  1  layer being read
wr_en  out  1  Dmem write enable, equal to rd_en delayed by PIPE_LAT
first_iter  out  1  high throughout iteration 0; the row unit forces D=0 while it is high
iter_count  out  ITERW  completed iterations
busy  out  1  high in READ and DRAIN
done  out  1  one-cycle pulse in DONE

Behaviour:
- Reset (rst=0 at a clock edge): all outputs 0, state IDLE, delay line cleared, early_term latch cleared. Reset overrides start in the same cycle. Reset mid-operation aborts immediately; no wr_en pulse may appear after reset, even for reads still in flight.
- States: IDLE, READ, DRAIN, DONE. All outputs are registered.
- IDLE -> READ on start=1. On that edge: latch max_iter (0 becomes 1), clear iter_count, set first_iter=1, rd_layer=0, address counter=0.
- READ: rd_en=1, rd_address=cnt. cnt runs 0..NADDR-1. After the cycle with cnt=NADDR-1, go to DRAIN and load drain counter=PIPE_LAT.
- DRAIN: rd_en=0, held for PIPE_LAT cycles. On the last drain cycle:
  - if rd_layer=0: rd_layer<=1, go to READ.
  - if rd_layer=1: iter_count+1; first_iter<=0; rd_layer<=0.
    - if the new iter_count equals the latched max_iter, or the early_term latch is set: go to DONE.
    - otherwise go to READ.
- DONE: done=1 for one cycle, busy=0, then IDLE. iter_count holds until the next accepted start.
- wr_en: a PIPE_LAT-deep shift of rd_en. The final write of a layer coincides with the last DRAIN cycle, so reads of the next layer never overlap writes of the previous one.
- start while busy or in DONE: ignored.
- early_term asserted in IDLE: ignored. The latch clears on an accepted start.
- Timing with NADDR=20, PIPE_LAT=4:
  - start at cycle 0 -> reads on cycles 1..20, writes on 5..24, layer-1 reads on 25..44.
  - One iteration is 48 cycles.
  - done is on cycle 49 + 48*(N-1) for N iterations.
- No wrap-around: iteration count saturates at max_iter ≤ 2^ITERW-1.

Decomposition:
- Shared package dmem_ctrl_pkg holds:
  - constants ADDRESSWIDTH, NADDR, default PIPE_LAT
  - state encoding IDLE=2'd0, READ=2'd1, DRAIN=2'd2, DONE=2'd3
- Sub-module dmem_wr_delay: a PIPE_LAT-stage 1-bit shift register with synchronous active-low clear, producing wr_en.

Test Plan:
- Reset, then start with max_iter=1 at cycle 0 -> rd_en on 1..20 with addresses 0..19, layer 0; rd_en on 25..44, layer 1; wr_en on 5..24 and 29..48; done=1 only on cycle 49; iter_count=1; first_iter high on cycles 1..48.
- max_iter=3 -> done on cycle 145, iter_count=3; first_iter low from cycle 49.
- max_iter=5, early_term pulsed on cycle 30 -> finishes iteration 0, done on cycle 49, iter_count=1.
- rst=0 on cycle 12 of layer 0 -> next cycle all outputs 0 and no wr_en on cycles 13..20; a fresh start afterwards restarts at address 0.
- start pulsed on cycle 10 while busy, and in the DONE cycle -> ignored; timing identical to the first scenario.
- max_iter=0 -> behaves as max_iter=1 (done on cycle 49). Rerun with PIPE_LAT=1 -> wr_en on 2..21, DRAIN lasts 1 cycle, done on cycle 43.

Source files
------------

// File: rtl/dmem_ctrl_pkg.sv
// Shared constants and state encoding for the D-memory access sequencer.
package dmem_ctrl_pkg;

    localparam int unsigned ADDRESSWIDTH     = 5;
    localparam int unsigned NADDR            = 20;
    localparam int unsigned PIPE_LAT_DEFAULT = 4;
    localparam int unsigned DRAINW           = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRead  = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } state_e;

endpackage

// File: rtl/dmem_wr_delay.sv
// Fixed-depth 1-bit shift register turning read enables into write-back enables.
module dmem_wr_delay #(
    parameter int unsigned PIPE_LAT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [PIPE_LAT-1:0] sr_q, sr_d;

    always_comb begin
        sr_d    = sr_q << 1;
        sr_d[0] = din;
    end

    // Synchronous clear drops in-flight writes when the sequencer is reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign dout = sr_q[PIPE_LAT-1];

endmodule

// File: rtl/dmem_access_ctrl.sv
// Layer-by-layer read sequencer for the D queue memory with delayed write-back enable.
module dmem_access_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int unsigned PIPE_LAT = PIPE_LAT_DEFAULT,
    parameter int unsigned ITERW    = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ITERW-1:0]        max_iter,
    input  logic                    early_term,
    output logic                    rd_en,
    output logic [ADDRESSWIDTH-1:0] rd_address,
    output logic                    rd_layer,
    output logic                    wr_en,
    output logic                    first_iter,
    output logic [ITERW-1:0]        iter_count,
    output logic                    busy,
    output logic                    done
);

    state_e                  state_q, state_d;
    logic [ADDRESSWIDTH-1:0] addr_q, addr_d;
    logic [DRAINW-1:0]       drain_q, drain_d;
    logic                    layer_q, layer_d;
    logic [ITERW-1:0]        iter_q, iter_d;
    logic [ITERW-1:0]        max_q, max_d;
    logic                    et_q, et_d;
    logic                    first_q, first_d;
    logic                    rd_en_q, rd_en_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        drain_d = drain_q;
        layer_d = layer_q;
        iter_d  = iter_q;
        max_d   = max_q;
        et_d    = et_q;
        first_d = first_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRead;
                    max_d   = (max_iter == '0) ? ITERW'(1) : max_iter;
                    iter_d  = '0;
                    first_d = 1'b1;
                    layer_d = 1'b0;
                    addr_d  = '0;
                    et_d    = 1'b0;
                end
            end
            StRead: begin
                et_d = et_q | early_term;
                if (addr_q == ADDRESSWIDTH'(NADDR - 1)) begin
                    state_d = StDrain;
                    drain_d = DRAINW'(PIPE_LAT);
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            StDrain: begin
                et_d = et_q | early_term;
                if (drain_q == DRAINW'(1)) begin
                    if (!layer_q) begin
                        layer_d = 1'b1;
                        state_d = StRead;
                    end else begin
                        iter_d  = iter_q + 1'b1;
                        first_d = 1'b0;
                        layer_d = 1'b0;
                        // Stopping on equality keeps the count from ever wrapping.
                        state_d = (iter_d == max_q || et_q) ? StDone : StRead;
                    end
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        rd_en_d = (state_d == StRead);
        busy_d  = (state_d == StRead) || (state_d == StDrain);
        done_d  = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            drain_q <= '0;
            layer_q <= 1'b0;
            iter_q  <= '0;
            max_q   <= '0;
            et_q    <= 1'b0;
            first_q <= 1'b0;
            rd_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            drain_q <= drain_d;
            layer_q <= layer_d;
            iter_q  <= iter_d;
            max_q   <= max_d;
            et_q    <= et_d;
            first_q <= first_d;
            rd_en_q <= rd_en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    dmem_wr_delay #(
        .PIPE_LAT(PIPE_LAT)
    ) u_wr_delay (
        .clk (clk),
        .rst (rst),
        .din (rd_en_q),
        .dout(wr_en)
    );

    assign rd_en      = rd_en_q;
    assign rd_address = addr_q;
    assign rd_layer   = layer_q;
    assign first_iter = first_q;
    assign iter_count = iter_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
